result_deconcat: RTL and testbench
==================================

RESULT_DECONCAT -- requirements
Module: result_deconcat

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = byte 0 (word_in[7:0]) is sent first; 0 = word_in[31:24] is sent first.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  one-cycle pulse; latches result_bytes and begins a new job.
REQ-005 SHALL have port result_bytes  in  32  total bytes to emit for the job; sampled only on start.
REQ-006 SHALL have port deconcat_en  in  1  word_in valid; a word is accepted only when deconcat_en && ready.
REQ-007 SHALL have port word_in  in  32  cache read data.
REQ-008 SHALL have port ready  out  1  able to accept a word.
REQ-009 SHALL have port axi_w_busy  in  1  AXI write channel busy; no request may be issued while it is high.
REQ-010 SHALL have port axi_w_success  in  1  one-cycle pulse; the current byte has been written.
REQ-011 SHALL have port axi_we  out  1  byte write request.
REQ-012 SHALL have port axi_wdata  out  8  byte to write.
REQ-013 SHALL have port deconcat_done  out  1  one-cycle pulse; the accepted word is fully sent (advances the cache address).
REQ-014 SHALL have port all_done  out  1  level; the job is complete.
REQ-015 SHALL have port bytes_sent  out  32  bytes acknowledged in the current job.

Function
REQ-016 SHALL implement the states IDLE, ISSUE and WAIT_ACK.
REQ-017 SHALL drive ready = (state==IDLE) && job_active && !all_done.
REQ-018 SHALL, on accepting a word, register it into a shift register, set byte_idx=0 and enter ISSUE on the next edge.
REQ-019 SHALL drive axi_we = (state==ISSUE) && !axi_w_busy, combinationally from the registered state.
REQ-020 SHALL move from ISSUE to WAIT_ACK on the edge where axi_we=1, and remain in ISSUE while axi_w_busy=1.
REQ-021 SHALL drive axi_wdata from the shift register head and hold it stable from ISSUE through WAIT_ACK.
REQ-022 SHALL, on axi_w_success in WAIT_ACK, increment bytes_sent by 1 and shift to the next byte per LSB_FIRST.
REQ-023 SHALL, on that acknowledgement, go to ISSUE if byte_idx<3 and bytes_sent+1<total.
REQ-024 SHALL otherwise, on that acknowledgement, pulse deconcat_done for one cycle and go to IDLE.
REQ-025 SHALL ignore axi_w_success outside WAIT_ACK.
REQ-026 SHALL set all_done on the edge where bytes_sent reaches total, and hold it until the next start or reset.
REQ-027 SHALL handle a partial last word: if total is not a multiple of 4, only total mod 4 bytes of the final word are sent, then deconcat_done pulses.
REQ-028 SHALL, when total=0, set all_done one cycle after start, keep ready=0, and never assert axi_we.
REQ-029 SHALL give start priority over every event: mid-operation start aborts, clears bytes_sent/byte_idx/all_done, returns to IDLE, and generates no deconcat_done for the aborted word.
REQ-030 SHALL ignore deconcat_en when ready=0; no word is lost or duplicated.
REQ-031 SHALL give minimum latency from word acceptance (edge t) to axi_we as cycle t+1 when axi_w_busy=0.
REQ-032 SHALL ensure bytes_sent never exceeds the latched total; the counter is 32-bit and does not wrap.
REQ-033 SHALL have no combinational path from word_in to any output.

Reset
REQ-034 SHALL, while rst_n=0, immediately force: state=IDLE, job_active=0, ready=0, axi_we=0, axi_wdata=0, deconcat_done=0, all_done=0, bytes_sent=0, shift register=0.
REQ-035 SHALL, after release of rst_n, take no action until start.

Verification
REQ-036 SHALL cover: start, result_bytes=8, words 0x44332211 and 0x88776655, immediate acks -> axi_wdata 11,22,33,44,55,66,77,88; deconcat_done twice; all_done after byte 8; bytes_sent=8.
REQ-037 SHALL cover: result_bytes=6 -> second word emits 55,66 only; deconcat_done pulses after 66; all_done=1; no third axi_we.
REQ-038 SHALL cover: axi_w_busy held high 5 cycles in ISSUE -> axi_we stays 0 for 5 cycles, then one pulse; byte count unaffected.
REQ-039 SHALL cover: LSB_FIRST=0, word 0xA1B2C3D4, result_bytes=4 -> A1,B2,C3,D4.
REQ-040 SHALL cover: start mid-word (after 2 acks), then a new job with result_bytes=4 -> bytes_sent=0, no stale deconcat_done, new job completes normally.
REQ-041 SHALL cover: rst_n low while in WAIT_ACK -> all outputs 0 immediately, before any clock edge; result_bytes=0 start -> all_done next cycle, ready=0.

Source files
------------

// File: rtl/result_deconcat.sv
// Purpose: splits accepted 32-bit words into a byte stream of AXI write requests, one byte in flight at a time.
// Latency: a word accepted on edge t raises axi_we in cycle t+1 when axi_w_busy is low; each byte then waits for its ack.
// Backpressure: ready drops while a word is being sent; axi_w_busy holds the request off without losing the byte.
module result_deconcat #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] result_bytes,
    input  logic        deconcat_en,
    input  logic [31:0] word_in,
    output logic        ready,
    input  logic        axi_w_busy,
    input  logic        axi_w_success,
    output logic        axi_we,
    output logic [7:0]  axi_wdata,
    output logic        deconcat_done,
    output logic        all_done,
    output logic [31:0] bytes_sent
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t      state;
    logic        job_active;
    logic [31:0] total;
    logic [31:0] shift_reg;
    logic [1:0]  byte_idx;

    // bytes_sent < total whenever an ack is accepted, so this increment cannot wrap
    logic [31:0] sent_next;
    logic        last_byte;
    logic [31:0] shift_next;

    assign sent_next = bytes_sent + 32'd1;
    // a word ends after its fourth byte or when the job's byte budget is used up (partial last word)
    assign last_byte = (byte_idx == 2'd3) || (sent_next >= total);

    // outputs decoded only from registered state, so word_in never reaches an output combinationally
    assign ready     = (state == IDLE) && job_active && !all_done;
    assign axi_we    = (state == ISSUE) && !axi_w_busy;
    assign axi_wdata = (LSB_FIRST != 0) ? shift_reg[7:0] : shift_reg[31:24];

    // next shift register contents once the head byte is acknowledged
    always_comb begin
        shift_next = shift_reg;
        if (LSB_FIRST != 0) begin
            shift_next = {8'h00, shift_reg[31:8]};
        end else begin
            shift_next = {shift_reg[23:0], 8'h00};
        end
    end

    // job control FSM; start overrides every other event, including a pending ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            job_active    <= 1'b0;
            total         <= 32'd0;
            shift_reg     <= 32'd0;
            byte_idx      <= 2'd0;
            bytes_sent    <= 32'd0;
            all_done      <= 1'b0;
            deconcat_done <= 1'b0;
        end else begin
            deconcat_done <= 1'b0;
            if (start) begin
                state      <= IDLE;
                job_active <= 1'b1;
                total      <= result_bytes;
                shift_reg  <= 32'd0;
                byte_idx   <= 2'd0;
                bytes_sent <= 32'd0;
                // an empty job is complete immediately, which also keeps ready low
                all_done   <= (result_bytes == 32'd0);
            end else begin
                case (state)
                    IDLE: begin
                        if (deconcat_en && ready) begin
                            shift_reg <= word_in;
                            byte_idx  <= 2'd0;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (!axi_w_busy) begin
                            state <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (axi_w_success) begin
                            bytes_sent <= sent_next;
                            shift_reg  <= shift_next;
                            if (sent_next == total) begin
                                all_done <= 1'b1;
                            end
                            if (last_byte) begin
                                deconcat_done <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                                state    <= ISSUE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_deconcat.sv
module tb_result_deconcat;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  en_v;
    logic [1:0]  busy_v;
    logic [1:0]  succ_v;
    logic [31:0] rb_v   [2];
    logic [31:0] word_v [2];
    wire  [1:0]  ready_v;
    wire  [1:0]  we_v;
    wire  [1:0]  done_v;
    wire  [1:0]  alld_v;
    wire  [7:0]  wd_v   [2];
    wire  [31:0] bs_v   [2];

    int          n_cmp;
    int          n_err;
    int          we_cnt;
    int          done_cnt [2];
    logic        auto_ack;
    logic [7:0]  exp_q [$];

    // instance 0: LSB first, instance 1: MSB first
    result_deconcat #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .result_bytes(rb_v[0]),
        .deconcat_en(en_v[0]), .word_in(word_v[0]), .ready(ready_v[0]),
        .axi_w_busy(busy_v[0]), .axi_w_success(succ_v[0]), .axi_we(we_v[0]),
        .axi_wdata(wd_v[0]), .deconcat_done(done_v[0]), .all_done(alld_v[0]),
        .bytes_sent(bs_v[0])
    );

    result_deconcat #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .result_bytes(rb_v[1]),
        .deconcat_en(en_v[1]), .word_in(word_v[1]), .ready(ready_v[1]),
        .axi_w_busy(busy_v[1]), .axi_w_success(succ_v[1]), .axi_we(we_v[1]),
        .axi_wdata(wd_v[1]), .deconcat_done(done_v[1]), .all_done(alld_v[1]),
        .bytes_sent(bs_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write request must match the next expected byte
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (we_v[k]) begin
                    we_cnt++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL wdata_unexpected: inst %0d got %h, expected no request", k, wd_v[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (wd_v[k] !== e) begin
                            n_err++;
                            $display("FAIL wdata: inst %0d got %h, expected %h", k, wd_v[k], e);
                        end
                    end
                end
                if (done_v[k]) done_cnt[k]++;
            end
        end
    end

    // AXI responder: acknowledges each request one cycle after it is issued
    initial begin
        logic [1:0] pend;
        pend   = 2'b00;
        succ_v = 2'b00;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                succ_v[k] = 1'b0;
                if (pend[k]) begin
                    succ_v[k] = 1'b1;
                    pend[k]   = 1'b0;
                end
                if (auto_ack && we_v[k]) pend[k] = 1'b1;
            end
        end
    end

    task automatic do_start(input int k, input logic [31:0] n);
        @(posedge clk); #1;
        start_v[k] = 1'b1;
        rb_v[k]    = n;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes, input bit lsb);
        for (int i = 0; i < nbytes; i++) begin
            if (lsb) exp_q.push_back(w[8*i +: 8]);
            else     exp_q.push_back(w[31-8*i -: 8]);
        end
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input bit chk_lat);
        bit ok;
        ok        = 1'b0;
        en_v[k]   = 1'b1;
        word_v[k] = w;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (ready_v[k]) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        en_v[k] = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: inst %0d got no ready, expected ready within 300 cycles", k);
        end else if (chk_lat) begin
            @(negedge clk);
            check("accept_to_we_latency", {31'd0, we_v[k]}, 32'd1);
        end
    endtask

    task automatic wait_all_done(input int k, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (alld_v[k]) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL all_done_timeout: inst %0d got all_done=0, expected 1 within %0d cycles", k, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int w0;
        bit ok;
        n_cmp = 0; n_err = 0; we_cnt = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        auto_ack = 1'b1;
        start_v = 2'b00; en_v = 2'b00; busy_v = 2'b00;
        rb_v[0] = 32'd0; rb_v[1] = 32'd0; word_v[0] = 32'd0; word_v[1] = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready",      {31'd0, ready_v[0]}, 32'd0);
        check("rst_axi_we",     {31'd0, we_v[0]},    32'd0);
        check("rst_wdata",      {24'd0, wd_v[0]},    32'd0);
        check("rst_done",       {31'd0, done_v[0]},  32'd0);
        check("rst_all_done",   {31'd0, alld_v[0]},  32'd0);
        check("rst_bytes_sent", bs_v[0],             32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_before_start", {31'd0, ready_v[0]}, 32'd0);

        // two full words, immediate acks
        do_start(0, 32'd8);
        check("start_ready", {31'd0, ready_v[0]}, 32'd1);
        d0 = done_cnt[0];
        push_word(32'h44332211, 4, 1'b1);
        push_word(32'h88776655, 4, 1'b1);
        send_word(0, 32'h44332211, 1'b1);
        send_word(0, 32'h88776655, 1'b0);
        wait_all_done(0, 200);
        check("full_bytes_sent", bs_v[0], 32'd8);
        check("full_done_pulses", done_cnt[0] - d0, 32'd2);
        check("full_queue_drained", exp_q.size(), 32'd0);
        check("full_ready_after", {31'd0, ready_v[0]}, 32'd0);

        // partial last word: six bytes
        do_start(0, 32'd6);
        check("partial_all_done_cleared", {31'd0, alld_v[0]}, 32'd0);
        d0 = done_cnt[0];
        w0 = we_cnt;
        push_word(32'h44332211, 4, 1'b1);
        push_word(32'h88776655, 2, 1'b1);
        send_word(0, 32'h44332211, 1'b0);
        send_word(0, 32'h88776655, 1'b0);
        wait_all_done(0, 200);
        repeat (8) @(negedge clk);
        check("partial_bytes_sent", bs_v[0], 32'd6);
        check("partial_done_pulses", done_cnt[0] - d0, 32'd2);
        check("partial_we_count", we_cnt - w0, 32'd6);
        check("partial_all_done_held", {31'd0, alld_v[0]}, 32'd1);

        // write channel busy for five cycles in ISSUE
        do_start(0, 32'd4);
        busy_v[0] = 1'b1;
        push_word(32'hDDCCBBAA, 4, 1'b1);
        send_word(0, 32'hDDCCBBAA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_we_low", {31'd0, we_v[0]}, 32'd0);
        end
        check("busy_bytes_sent", bs_v[0], 32'd0);
        @(posedge clk); #1;
        busy_v[0] = 1'b0;
        @(negedge clk);
        check("busy_release_we", {31'd0, we_v[0]}, 32'd1);
        wait_all_done(0, 200);
        check("busy_bytes_total", bs_v[0], 32'd4);

        // abort mid-word after two acks, then a clean job
        do_start(0, 32'd8);
        d0 = done_cnt[0];
        push_word(32'h44332211, 3, 1'b1);
        send_word(0, 32'h44332211, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bs_v[0] == 32'd2) ok = 1'b1;
        end
        check("abort_reached_two", {31'd0, ok}, 32'd1);
        do_start(0, 32'd4);
        check("abort_bytes_cleared", bs_v[0], 32'd0);
        check("abort_all_done", {31'd0, alld_v[0]}, 32'd0);
        check("abort_ready", {31'd0, ready_v[0]}, 32'd1);
        check("abort_no_done", done_cnt[0] - d0, 32'd0);
        push_word(32'h44332211, 4, 1'b1);
        send_word(0, 32'h44332211, 1'b1);
        wait_all_done(0, 200);
        check("abort_new_bytes", bs_v[0], 32'd4);
        check("abort_new_done", done_cnt[0] - d0, 32'd1);

        // MSB-first ordering
        do_start(1, 32'd4);
        push_word(32'hA1B2C3D4, 4, 1'b0);
        send_word(1, 32'hA1B2C3D4, 1'b1);
        wait_all_done(1, 200);
        check("msb_bytes_sent", bs_v[1], 32'd4);
        check("msb_done_pulses", done_cnt[1], 32'd1);

        // reset while waiting for an ack, then an empty job
        auto_ack = 1'b0;
        do_start(0, 32'd4);
        push_word(32'h44332211, 1, 1'b1);
        send_word(0, 32'h44332211, 1'b1);
        @(posedge clk); #2;
        check("pre_reset_wdata", {24'd0, wd_v[0]}, 32'h11);
        rst_n = 1'b0;
        #1;
        check("async_rst_wdata", {24'd0, wd_v[0]}, 32'd0);
        check("async_rst_we",    {31'd0, we_v[0]},  32'd0);
        check("async_rst_ready", {31'd0, ready_v[0]}, 32'd0);
        check("async_rst_all_done", {31'd0, alld_v[0]}, 32'd0);
        check("async_rst_done",  {31'd0, done_v[0]}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        auto_ack = 1'b1;
        w0 = we_cnt;
        do_start(0, 32'd0);
        check("zero_all_done", {31'd0, alld_v[0]}, 32'd1);
        check("zero_ready", {31'd0, ready_v[0]}, 32'd0);
        en_v[0] = 1'b1;
        word_v[0] = 32'hFFFFFFFF;
        repeat (6) @(negedge clk);
        en_v[0] = 1'b0;
        check("zero_no_we", we_cnt - w0, 32'd0);
        check("zero_bytes_sent", bs_v[0], 32'd0);
        check("final_queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
